// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared types and constants for the IO bus initiator.
//   io_state_t : bus-cycle sequencer states
//   io_size_t  : load/store access size
//   io_req_t   : captured CPU request
//   req_legal(): alignment + IO-window check on an incoming request
package io_bus_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} io_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} io_size_t;

  localparam int          NUM_LANES      = 4;
  localparam logic [15:0] IO_BASE_HI_DEF = 16'hFFFF;

  // Responder register offsets (Address[15:0]).
  localparam logic [15:0] REG_SW       = 16'h0000;
  localparam logic [15:0] REG_LEDR     = 16'h0004;
  localparam logic [15:0] REG_HEX      = 16'h0008;
  localparam logic [15:0] REG_LCD_CMD  = 16'h000C;
  localparam logic [15:0] REG_LCD_DATA = 16'h0010;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    io_size_t    size;
    logic        uns;
  } io_req_t;

  function automatic logic req_legal(input logic [31:0] addr, input io_size_t size,
                                     input logic [15:0] base);
    logic ok;
    ok = (addr[31:16] == base);
    case (size)
      SZ_B:    ;
      SZ_H:    if (addr[0]) ok = 1'b0;
      SZ_W:    if (addr[1:0] != 2'b00) ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/io_lane_align.sv
// io_lane_align: combinational byte-lane steering for the IO bus.
//   addr_lo, size, uns : access descriptor
//   wdata  -> wlanes   : right-justified store data replicated across lanes
//   be                 : active-high lane enables
//   rdata  -> rdata_ext: selected lane shifted to bit 0, sign/zero extended
module io_lane_align
  import io_bus_pkg::*;
(
  input  logic [1:0]                 addr_lo,
  input  io_size_t                   size,
  input  logic                       uns,
  input  logic [31:0]                wdata,
  input  logic [31:0]                rdata,
  output logic [NUM_LANES-1:0]       be,
  output logic [NUM_LANES-1:0][7:0]  wlanes,
  output logic [31:0]                rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    be = 4'b1111;
    case (size)
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
  end

  // Replicate so whichever lane the responder decodes sees the right data.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wlanes[i] = (size == SZ_B) ? wdata[7:0] :
                       (size == SZ_H) ? wdata[(i%2)*8 +: 8] :
                                        wdata[i*8 +: 8];
  end

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    rdata_ext = shifted;
    case (size)
      SZ_B:    rdata_ext = {{24{~uns & shifted[7]}},  shifted[7:0]};
      SZ_H:    rdata_ext = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: rdata_ext = shifted;  // word: addr_lo is 0, uns ignored
    endcase
  end

endmodule

// File: rtl/io_bus_initiator.sv
// io_bus_initiator: sequences one CPU load/store at a time onto the strobed
// IO bus and returns a single-cycle response.
//   Clock, Reset_L        : clock, async active-low reset
//   req_*                 : valid/ready request from the load/store unit
//   rsp_*                 : one-cycle response pulse (no backpressure)
//   AS_L, WE_L, IO_Select,
//   Address, byte_enable,
//   IO_data_out/IO_data_in: bus toward the IO responder
module io_bus_initiator
  import io_bus_pkg::*;
#(
  parameter logic [15:0] IO_BASE_HI    = IO_BASE_HI_DEF,
  parameter int          STROBE_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset_L,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        AS_L,
  output logic        WE_L,
  output logic        IO_Select,
  output logic [31:0] Address,
  output logic [31:0] IO_data_out,
  output logic [3:0]  byte_enable,
  input  logic [31:0] IO_data_in
);

  localparam logic [3:0] STB_N = 4'(STROBE_CYCLES);

  io_state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  io_req_t    req_in, req_q, cur;
  logic       err_q, legal, bus_on;
  logic [31:0] rdata_q, rdata_ext;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wlanes;

  assign req_in = '{write: req_write, addr: req_addr, wdata: req_wdata,
                    size: io_size_t'(req_size), uns: req_unsigned};
  assign legal  = req_legal(req_addr, io_size_t'(req_size), IO_BASE_HI);
  // In IDLE the incoming request drives the lane logic so SETUP outputs can
  // be registered on the accepting edge; afterwards the captured copy does.
  assign cur       = (state == IDLE) ? req_in : req_q;
  assign req_ready = (state == IDLE);

  io_lane_align u_align (
    .addr_lo   (cur.addr[1:0]),
    .size      (cur.size),
    .uns       (cur.uns),
    .wdata     (cur.wdata),
    .rdata     (rdata_q),
    .be        (be),
    .wlanes    (wlanes),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE:   if (req_valid) state_d = legal ? SETUP : RESP;
      SETUP:  begin state_d = STROBE; cnt_d = 4'd1; end
      STROBE: if (cnt == STB_N) state_d = HOLD;
              else              cnt_d   = cnt + 4'd1;
      HOLD:   state_d = RESP;
      RESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and load-data sample at the edge ending the last strobe.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      req_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (req_valid && req_ready) begin
        req_q <= req_in;
        err_q <= ~legal;
      end
      if (state == STROBE && cnt == STB_N && !req_q.write)
        rdata_q <= IO_data_in;
    end
  end

  assign bus_on = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);

  // All pins are registered from the next state, so async reset releases the
  // strobes immediately. The response register trails RESP by one edge.
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      AS_L        <= 1'b1;
      WE_L        <= 1'b1;
      IO_Select   <= 1'b0;
      Address     <= '0;
      IO_data_out <= '0;
      byte_enable <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
    end else begin
      AS_L        <= (state_d != STROBE);
      WE_L        <= ~((state_d == STROBE) && cur.write);
      IO_Select   <= bus_on;
      Address     <= bus_on ? cur.addr : '0;
      IO_data_out <= bus_on ? wlanes   : '0;
      byte_enable <= bus_on ? be       : '0;
      rsp_valid   <= (state == RESP);
      rsp_error   <= (state == RESP) && err_q;
      rsp_rdata   <= (state == RESP && !err_q && !req_q.write) ? rdata_ext : '0;
    end
  end

endmodule

// File: tb/tb_io_bus_initiator.sv
module tb_io_bus_initiator;
  import io_bus_pkg::*;

  logic        Clock = 1'b0, Reset_L = 1'b0;
  logic        req_valid = 1'b0, req_valid1 = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, IO_data_in = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_error, AS_L, WE_L, IO_Select;
  logic [31:0] rsp_rdata, Address, IO_data_out;
  logic [3:0]  byte_enable;
  logic        req_ready1, rsp_valid1, rsp_error1, AS_L1, WE_L1, IO_Select1;
  logic [31:0] rsp_rdata1, Address1, IO_data_out1;
  logic [3:0]  byte_enable1;

  always #5 Clock = ~Clock;

  io_bus_initiator dut (
    .Clock(Clock), .Reset_L(Reset_L), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .AS_L(AS_L), .WE_L(WE_L),
    .IO_Select(IO_Select), .Address(Address), .IO_data_out(IO_data_out),
    .byte_enable(byte_enable), .IO_data_in(IO_data_in));

  io_bus_initiator #(.STROBE_CYCLES(1)) dut1 (
    .Clock(Clock), .Reset_L(Reset_L), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_error(rsp_error1), .AS_L(AS_L1), .WE_L(WE_L1),
    .IO_Select(IO_Select1), .Address(Address1), .IO_data_out(IO_data_out1),
    .byte_enable(byte_enable1), .IO_data_in(IO_data_in));

  typedef struct { logic [31:0] rdata; logic err; int due; } rsp_exp_t;
  typedef struct { logic we; logic [3:0] be; logic [31:0] dout; logic [31:0] addr; } bus_exp_t;

  rsp_exp_t rsp_q[$];
  bus_exp_t bus_q[$];
  int checks = 0, errors = 0, cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response scoreboard: pops one expectation per rsp_valid pulse.
  always @(negedge Clock) begin
    rsp_exp_t e;
    if (Reset_L && rsp_valid) begin
      if (rsp_q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        e = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
        chk("rsp_cycle", cyc, e.due);
      end
    end
  end

  // Bus scoreboard: checks pins on the first strobe cycle and the strobe width.
  int   low_n = 0;
  logic prev_as = 1'b1;
  always @(negedge Clock) begin
    bus_exp_t b;
    if (!Reset_L) begin
      low_n = 0; prev_as = 1'b1;
    end else begin
      if (!AS_L) begin
        if (prev_as) begin
          if (bus_q.size() == 0) chk("unexpected_strobe", 1, 0);
          else begin
            b = bus_q.pop_front();
            chk("WE_L", {31'd0, WE_L}, {31'd0, ~b.we});
            chk("byte_enable", {28'd0, byte_enable}, {28'd0, b.be});
            chk("IO_data_out", IO_data_out, b.dout);
            chk("Address", Address, b.addr);
            chk("IO_Select", {31'd0, IO_Select}, 32'd1);
          end
        end
        low_n++;
      end else if (!prev_as) begin
        chk("strobe_len", low_n, 2);
        chk("hold_WE_L", {31'd0, WE_L}, 32'd1);
        chk("hold_IO_Select", {31'd0, IO_Select}, 32'd1);
        low_n = 0;
      end
      prev_as = AS_L;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u, input logic [31:0] din,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input logic [3:0] exp_be, input logic [31:0] exp_dout,
                       output int acc);
    int n;
    @(negedge Clock);
    req_write = w; req_addr = a; req_wdata = wd; req_size = sz;
    req_unsigned = u; IO_data_in = din; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 40) begin @(negedge Clock); n++; end
    chk("accept_wait", {31'd0, req_ready}, 32'd1);
    acc = cyc + 1;
    rsp_q.push_back('{exp_rd, exp_err, acc + (exp_err ? 1 : 5)});
    if (!exp_err) bus_q.push_back('{w, exp_be, exp_dout, a});
    @(posedge Clock);
  endtask

  task automatic drain();
    int n;
    @(negedge Clock);
    req_valid = 1'b0;
    n = 0;
    while (rsp_q.size() != 0 && n < 60) begin @(negedge Clock); n++; end
    chk("drain", rsp_q.size(), 0);
  endtask

  initial begin
    int a0, a1, a2, t0, n, bad;
    repeat (3) @(negedge Clock);
    chk("rst_ctrl", {26'd0, AS_L, WE_L, IO_Select, rsp_valid, rsp_error, req_ready}, 32'b110001);
    chk("rst_Address", Address, 0);
    chk("rst_IO_data_out", IO_data_out, 0);
    chk("rst_be_rdata", {byte_enable, rsp_rdata[27:0]}, 0);
    @(negedge Clock); #2 Reset_L = 1'b1;

    // store word HEX
    issue(1, 32'hFFFF0008, 32'h00123456, 2'd2, 0, 0, 0, 0, 4'hF, 32'h00123456, a0);
    drain();
    // load byte lane 3, signed and unsigned
    issue(0, 32'hFFFF0003, 0, 2'd0, 0, 32'h80FF0000, 32'hFFFFFF80, 0, 4'b1000, 0, a0);
    drain();
    issue(0, 32'hFFFF0003, 0, 2'd0, 1, 32'h80FF0000, 32'h00000080, 0, 4'b1000, 0, a0);
    drain();
    // load half upper, positive; load half lower, negative
    issue(0, 32'hFFFF0002, 0, 2'd1, 0, 32'h7FFE0000, 32'h00007FFE, 0, 4'b1100, 0, a0);
    drain();
    issue(0, 32'hFFFF0000, 0, 2'd1, 0, 32'h00008001, 32'hFFFF8001, 0, 4'b0011, 0, a0);
    drain();
    // word load ignores req_unsigned / sign
    issue(0, 32'hFFFF0010, 0, 2'd2, 1, 32'h87654321, 32'h87654321, 0, 4'hF, 0, a0);
    drain();
    // store byte / half replication
    issue(1, 32'hFFFF0005, 32'h000000A5, 2'd0, 0, 0, 0, 0, 4'b0010, 32'hA5A5A5A5, a0);
    drain();
    issue(1, 32'hFFFF0002, 32'h0000BEEF, 2'd1, 0, 0, 0, 0, 4'b1100, 32'hBEEFBEEF, a0);
    drain();

    // errors: misaligned word, outside window, reserved size, misaligned half
    issue(0, 32'hFFFF0006, 0, 2'd2, 0, 0, 0, 1, 0, 0, a0);
    @(negedge Clock); req_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (!AS_L || IO_Select) bad++;
      @(negedge Clock);
    end
    chk("err_no_bus", bad, 0);
    drain();
    issue(1, 32'h00000004, 32'h1, 2'd2, 0, 0, 0, 1, 0, 0, a0);
    drain();
    issue(0, 32'hFFFF0000, 0, 2'd3, 0, 0, 0, 1, 0, 0, a0);
    drain();
    issue(0, 32'hFFFF0001, 0, 2'd1, 0, 0, 0, 1, 0, 0, a0);
    drain();

    // back-to-back stores to LEDR with req_valid held high
    issue(1, 32'hFFFF0004, 32'h1, 2'd2, 0, 0, 0, 0, 4'hF, 32'h1, a0);
    issue(1, 32'hFFFF0004, 32'h2, 2'd2, 0, 0, 0, 0, 4'hF, 32'h2, a1);
    issue(1, 32'hFFFF0004, 32'h3, 2'd2, 0, 0, 0, 0, 4'hF, 32'h3, a2);
    drain();
    chk("b2b_gap1", a1 - a0, 6);
    chk("b2b_gap2", a2 - a1, 6);

    // STROBE_CYCLES=1 instance: response after edge 4
    @(negedge Clock);
    req_write = 1; req_addr = 32'hFFFF0004; req_wdata = 32'h55; req_size = 2'd2;
    req_valid1 = 1'b1; t0 = cyc + 1;
    @(negedge Clock); req_valid1 = 1'b0;
    n = 0;
    while (!rsp_valid1 && n < 20) begin @(negedge Clock); n++; end
    chk("s1_rsp_seen", {31'd0, rsp_valid1}, 32'd1);
    chk("s1_latency", cyc - t0, 4);
    chk("s1_rdata_err", {rsp_error1, rsp_rdata1[30:0]}, 0);
    repeat (2) @(negedge Clock);

    // reset during STROBE
    issue(1, 32'hFFFF000C, 32'h41, 2'd2, 0, 0, 0, 0, 4'hF, 32'h41, a0);
    @(negedge Clock); req_valid = 1'b0;
    n = 0;
    while (AS_L && n < 10) begin @(negedge Clock); n++; end
    chk("pre_rst_strobe", {31'd0, AS_L}, 32'd0);
    #2 Reset_L = 1'b0;
    #1;
    chk("rst_mid_pins", {29'd0, AS_L, WE_L, req_ready}, 32'b111);
    rsp_q.delete(); bus_q.delete();
    repeat (2) @(negedge Clock);
    #2 Reset_L = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (rsp_valid || !AS_L) bad++;
    end
    chk("no_rsp_after_reset", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_bus_initiator.md
Name: io_bus_initiator

Overview:
- Master-side sequencer for the memory-mapped IO bus: AS_L, WE_L, IO_Select, Address, byte_enable and the data buses.
- Accepts one CPU load/store request at a time through a valid/ready handshake.
- Runs a multi-cycle strobed bus cycle toward the IO responder, then returns byte-lane-aligned, sign- or zero-extended read data in a single-cycle response pulse.
- Sits between the core's load/store unit and the IO responder that drives switches, LEDs, HEX and LCD.

Parameters:
- IO_BASE_HI, 16'hFFFF: value of req_addr[31:16] that selects the IO window.
- STROBE_CYCLES, 2: number of cycles AS_L is held low. Legal range is 1..15.

Ports:
- Clock  in  1  system clock
- Reset_L  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  initiator idle; the request is accepted when req_valid && req_ready on a rising edge
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  zero-extend load (lbu/lhu)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_error  out  1  request rejected with no bus cycle run
- AS_L  out  1  address strobe, active low
- WE_L  out  1  write enable, active low
- IO_Select  out  1  IO window select
- Address  out  32  registered bus address
- IO_data_out  out  32  lane-replicated write data to the responder
- byte_enable  out  4  active-high lane enables
- IO_data_in  in  32  read data from the responder

Behaviour:
- Reset values: AS_L=1, WE_L=1, IO_Select=0, Address=0, IO_data_out=0, byte_enable=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, state=IDLE. req_ready is 1 whenever the state is IDLE, including during reset.
- Reset asserted mid-operation: strobes deassert asynchronously, the FSM returns to IDLE, and no response is issued.
- FSM states: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE: on acceptance, capture the request.
  - If the request is legal, go to SETUP.
  - If it is illegal, go to RESP with rsp_error=1. No bus pins change.
- Illegal requests:
  - req_size=3.
  - size=1 with addr[0]=1.
  - size=2 with addr[1:0]!=0.
  - req_addr[31:16] != IO_BASE_HI.
- SETUP (1 cycle): Address, IO_Select=1, byte_enable and IO_data_out are driven. AS_L=1, WE_L=1.
- STROBE (STROBE_CYCLES cycles): AS_L=0 and WE_L=~write. A 4-bit counter counts the strobe cycles.
  - On loads, IO_data_in is sampled on the rising edge that ends the last STROBE cycle.
- HOLD (1 cycle): AS_L=1 and WE_L=1. Address, IO_Select and byte_enable stay held. WE_L deasserts no later than AS_L.
- RESP (1 cycle): rsp_valid=1 with rsp_rdata and rsp_error. Bus outputs return to their reset values. Next state is IDLE.
- There is no response backpressure; the consumer must take rsp_valid when it pulses.
- Latency: with the accepting edge counted as edge 0, rsp_valid is high in the cycle after edge STROBE_CYCLES+3 for legal requests (edge 5 at the default), and after edge 1 for errors. Throughput is one request per STROBE_CYCLES+4 cycles.
- byte_enable:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
- Write lanes:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Read extract: the lane selected by addr[1:0] is shifted to bit 0, then sign-extended from bit 7 or 15 unless req_unsigned=1. Word loads ignore req_unsigned.
- req_valid asserted while not IDLE is ignored and not queued, because req_ready=0.
- Address[15:0] carries the full register offset, so the responder's 16-bit decode is satisfied.

Decomposition:
- Shared package io_bus_pkg holds:
  - state enum io_state_t.
  - size enum io_size_t {SZ_B, SZ_H, SZ_W, SZ_RSV}.
  - IO_BASE_HI default.
  - Register offsets: SW 16'h0000, LEDR 16'h0004, HEX 16'h0008, LCD_CMD 16'h000C, LCD_DATA 16'h0010.
- One combinational sub-module io_lane_align holds byte_enable generation, write replication, and read extract/extend. The FSM, counter and capture registers live in the top.

Test Plan:
- Reset: hold Reset_L=0 mid-STROBE → AS_L=1 and WE_L=1 immediately, req_ready=1, no rsp_valid after release.
- Store word to 32'hFFFF0008 with wdata 32'h00123456 → AS_L low exactly 2 cycles, WE_L=0, byte_enable=4'hF, IO_data_out=32'h00123456; rsp_valid at edge 5 with rsp_rdata=0.
- Load byte from 32'hFFFF0003, responder returns 32'h80FF_0000, req_unsigned=0 → rsp_rdata=32'hFFFF_FF80. Same load with req_unsigned=1 → 32'h0000_0080.
- Load half from 32'hFFFF0002, responder returns 32'h7FFE_0000 → byte_enable=4'b1100, rsp_rdata=32'h0000_7FFE.
- Misaligned word at 32'hFFFF0006, and address 32'h0000_0004 outside the window → rsp_error=1 at edge 1, AS_L never low, IO_Select stays 0.
- Back-to-back: req_valid held high for 3 stores → each accepted only when req_ready=1, spaced 6 cycles apart, no overlap of AS_L pulses; STROBE_CYCLES=1 variant → rsp at edge 4.
